seq_divider_n: RTL and testbench

SEQ_DIVIDER_N -- requirements
Module: seq_divider_n

---
 rtl/seq_divider_n.sv | 143 ++++++++++++++
 tb/tb_seq_divider_n.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/seq_divider_n.sv
// Sequential restoring divider: one quotient bit per cycle, MSB first, with optional
// two's-complement operands handled by magnitude division plus a final sign fix-up.
module seq_divider_n #(
  parameter int unsigned          WIDTH     = 16,
  parameter bit                   SIGNED_EN = 1'b0,
  parameter logic [WIDTH-1:0]     DIVZERO_Q = '1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             div_zero
);

  localparam int unsigned CntW = $clog2(WIDTH);

  typedef enum logic [1:0] {StIdle, StRun, StFix} state_e;

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;     // partial remainder (or raw dividend on divide-by-zero)
  logic [WIDTH-1:0] dq_q, dq_d;       // dividend bits shift out, quotient bits shift in
  logic [WIDTH-1:0] div_q, div_d;
  logic             neg_quot_q, neg_quot_d;
  logic             neg_rem_q, neg_rem_d;
  logic             dz_q, dz_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dzo_q, dzo_d;
  logic             done_q, done_d;

  logic             sm;
  logic [WIDTH-1:0] a_abs, b_abs;
  logic [WIDTH:0]   shifted, diff;
  logic             ge;

  assign sm    = SIGNED_EN && signed_mode;
  assign a_abs = (sm && a[WIDTH-1]) ? -a : a;
  assign b_abs = (sm && b[WIDTH-1]) ? -b : b;

  // diff stays within -div..div-1, so its top bit is a reliable borrow flag.
  assign shifted = {acc_q, dq_q[WIDTH-1]};
  assign diff    = shifted - {1'b0, div_q};
  assign ge      = ~diff[WIDTH];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    dq_d       = dq_q;
    div_d      = div_q;
    neg_quot_d = neg_quot_q;
    neg_rem_d  = neg_rem_q;
    dz_d       = dz_q;
    quot_d     = quot_q;
    rem_d      = rem_q;
    dzo_d      = dzo_q;
    done_d     = 1'b0;

    unique case (state_q)
      StIdle: ;
      StRun: begin
        acc_d = ge ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
        dq_d  = {dq_q[WIDTH-2:0], ge};
        cnt_d = cnt_q - CntW'(1);
        if (cnt_q == '0) state_d = StFix;
      end
      StFix: begin
        done_d  = 1'b1;
        dzo_d   = dz_q;
        quot_d  = dz_q ? DIVZERO_Q : (neg_quot_q ? -dq_q : dq_q);
        rem_d   = (neg_rem_q && !dz_q) ? -acc_q : acc_q;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // A start in any state (re)launches; a FIX-cycle start keeps the done computed above.
    if (start) begin
      if (b == '0) begin
        state_d    = StFix;
        dz_d       = 1'b1;
        acc_d      = a;
        dq_d       = '0;
        cnt_d      = '0;
        neg_quot_d = 1'b0;
        neg_rem_d  = 1'b0;
      end else begin
        state_d    = StRun;
        dz_d       = 1'b0;
        acc_d      = '0;
        dq_d       = a_abs;
        div_d      = b_abs;
        cnt_d      = CntW'(WIDTH - 1);
        neg_quot_d = sm && (a[WIDTH-1] ^ b[WIDTH-1]);
        neg_rem_d  = sm && a[WIDTH-1];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      acc_q      <= '0;
      dq_q       <= '0;
      div_q      <= '0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      dz_q       <= 1'b0;
      quot_q     <= '0;
      rem_q      <= '0;
      dzo_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      dq_q       <= dq_d;
      div_q      <= div_d;
      neg_quot_q <= neg_quot_d;
      neg_rem_q  <= neg_rem_d;
      dz_q       <= dz_d;
      quot_q     <= quot_d;
      rem_q      <= rem_d;
      dzo_q      <= dzo_d;
      done_q     <= done_d;
    end
  end

  assign busy     = (state_q != StIdle);
  assign done     = done_q;
  assign q        = quot_q;
  assign r        = rem_q;
  assign div_zero = dzo_q;

endmodule

// File: tb/tb_seq_divider_n.sv
// Self-checking bench for seq_divider_n: directed corner cases plus random operands
// compared against an arithmetic reference model.
module tb_seq_divider_n;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         start;
  logic         signed_mode;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] q;
  logic [W-1:0] r;
  logic         div_zero;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seq_divider_n #(
    .WIDTH    (W),
    .SIGNED_EN(1'b1)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .signed_mode(signed_mode),
    .a          (a),
    .b          (b),
    .busy       (busy),
    .done       (done),
    .q          (q),
    .r          (r),
    .div_zero   (div_zero)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer division (SV int division truncates toward zero).
  function automatic void model(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic sm,
                                output logic [W-1:0] eq, output logic [W-1:0] er,
                                output logic ez);
    int sa, sb, qi, ri;
    if (ib == '0) begin
      eq = '1;
      er = ia;
      ez = 1'b1;
    end else if (sm) begin
      sa = int'($signed(ia));
      sb = int'($signed(ib));
      qi = sa / sb;
      ri = sa % sb;
      eq = qi[W-1:0];
      er = ri[W-1:0];
      ez = 1'b0;
    end else begin
      eq = ia / ib;
      er = ia % ib;
      ez = 1'b0;
    end
  endfunction

  // Present a start for one edge, then scramble operands to show they are not re-read.
  task automatic launch(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic sm);
    @(negedge clk);
    a           = ia;
    b           = ib;
    signed_mode = sm;
    start       = 1'b1;
    @(posedge clk);
    #1;
    start       = 1'b0;
    a           = W'($urandom);
    b           = W'($urandom);
    signed_mode = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_done(input string tag, input int exp_lat);
    int lat;
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = n;
        break;
      end
    end
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] ia, input logic [W-1:0] ib,
                        input logic sm);
    logic [W-1:0] eq, er;
    logic         ez;
    model(ia, ib, sm, eq, er, ez);
    launch(ia, ib, sm);
    check({tag, "_busy"}, 32'(busy), 32'(1));
    wait_done(tag, (ib == '0) ? 1 : W + 1);
    check({tag, "_q"}, 32'(q), 32'(eq));
    check({tag, "_r"}, 32'(r), 32'(er));
    check({tag, "_dz"}, 32'(div_zero), 32'(ez));
    check({tag, "_busy_at_done"}, 32'(busy), 32'(0));
    @(posedge clk);
    #1;
    check({tag, "_done_pulse"}, 32'(done), 32'(0));
    check({tag, "_q_hold"}, 32'(q), 32'(eq));
  endtask

  initial begin
    logic [W-1:0] ra, rb, eq, er;
    logic         rsm, ez;
    int           dcount, lat;
    logic [W-1:0] qcap, rcap;

    reset_n     = 1'b0;
    start       = 1'b0;
    signed_mode = 1'b0;
    a           = '0;
    b           = '0;
    #12;
    check("reset_busy", 32'(busy), 32'(0));
    check("reset_done", 32'(done), 32'(0));
    check("reset_q", 32'(q), 32'(0));
    check("reset_r", 32'(r), 32'(0));
    check("reset_dz", 32'(div_zero), 32'(0));
    #5 reset_n = 1'b1;
    dcount = 0;
    repeat (4) begin
      @(posedge clk);
      #1;
      if (done) dcount++;
    end
    check("idle_no_done", 32'(dcount), 32'(0));

    run_op("u_65280_51", 16'd65280, 16'd51, 1'b0);
    run_op("u_100_7", 16'd100, 16'd7, 1'b0);
    run_op("u_div0", 16'd5, 16'd0, 1'b0);
    run_op("s_m7_2", 16'hFFF9, 16'd2, 1'b1);
    run_op("s_ovf", 16'h8000, 16'hFFFF, 1'b1);
    run_op("s_div0", 16'hFFF0, 16'd0, 1'b1);
    run_op("u_max_1", 16'hFFFF, 16'd1, 1'b0);
    run_op("u_small_big", 16'd3, 16'hFFFF, 1'b0);
    run_op("s_7_m2", 16'd7, 16'hFFFE, 1'b1);

    // Abort: restart at edge +5; only the second operation may complete.
    launch(16'd1000, 16'd3, 1'b0);
    repeat (4) @(posedge clk);
    launch(16'd9, 16'd4, 1'b0);
    dcount = 0;
    lat    = -1;
    qcap   = '0;
    rcap   = '0;
    for (int n = 1; n <= 30; n++) begin
      @(posedge clk);
      #1;
      if (done) begin
        dcount++;
        lat  = n;
        qcap = q;
        rcap = r;
      end
    end
    check("abort_done_count", 32'(dcount), 32'(1));
    check("abort_latency", 32'(lat), 32'(W + 1));
    check("abort_q", 32'(qcap), 32'(2));
    check("abort_r", 32'(rcap), 32'(1));

    // Start landing in the FIX cycle: old done survives, new op starts on that edge.
    launch(16'd200, 16'd9, 1'b0);
    repeat (16) @(posedge clk);
    launch(16'd777, 16'd5, 1'b0);
    check("fixstart_done", 32'(done), 32'(1));
    check("fixstart_q", 32'(q), 32'(22));
    check("fixstart_r", 32'(r), 32'(2));
    check("fixstart_busy", 32'(busy), 32'(1));
    wait_done("fixstart_second", W + 1);
    check("fixstart_second_q", 32'(q), 32'(155));
    check("fixstart_second_r", 32'(r), 32'(2));

    // Asynchronous reset mid-RUN.
    launch(16'd60000, 16'd7, 1'b0);
    repeat (5) @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("areset_busy", 32'(busy), 32'(0));
    check("areset_done", 32'(done), 32'(0));
    check("areset_q", 32'(q), 32'(0));
    check("areset_r", 32'(r), 32'(0));
    check("areset_dz", 32'(div_zero), 32'(0));
    #4 reset_n = 1'b1;
    dcount = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (done || busy) dcount++;
    end
    check("areset_quiet", 32'(dcount), 32'(0));
    run_op("after_reset", 16'd60000, 16'd7, 1'b0);

    for (int i = 0; i < 25; i++) begin
      ra  = W'($urandom);
      rb  = W'($urandom);
      if ($urandom_range(0, 3) == 0) rb = W'($urandom_range(1, 20));
      if ($urandom_range(0, 7) == 0) rb = '0;
      rsm = 1'($urandom_range(0, 1));
      model(ra, rb, rsm, eq, er, ez);
      run_op($sformatf("rand%0d", i), ra, rb, rsm);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
